tluh_amo_unit: RTL and testbench

- Sequential, parametrised atomic-memory-operation unit for the TL-UH slave path.
- Consumes a stream of operand beats: op1 = old memory data, op2 = request data. Returns the new data to write back.
- Supports operands wider than the bus by chaining beats, least-significant beat first. Carry and compare state are carried between beats.
- Covers the full TL-UH atomic set: arithmetic (MIN, MAX, MINU, MAXU, ADD) and logical (XOR, OR, AND, SWAP), with byte masking.

---
 rtl/tluh_pkg.sv | 40 ++++
 rtl/tluh_amo_beat_alu.sv | 40 ++++
 rtl/tluh_amo_unit.sv | 158 +++++++++++++++
 tb/tb_tluh_amo_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tluh_pkg.sv
// ============================================================================
// Module   : tluh_pkg
// Brief    : Shared types and constants for the TL-UH atomic memory unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tluh_pkg;

    localparam int TL_DW = 32;

    typedef enum logic [2:0] {
        MIN  = 3'd0,
        MAX  = 3'd1,
        MINU = 3'd2,
        MAXU = 3'd3,
        ADD  = 3'd4
    } amo_arith_e;

    typedef enum logic [2:0] {
        XOR  = 3'd0,
        OR   = 3'd1,
        AND  = 3'd2,
        SWAP = 3'd3
    } amo_logic_e;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } amo_state_e;

    typedef struct packed {
        logic [TL_DW-1:0]   op1;
        logic [TL_DW-1:0]   op2;
        logic [TL_DW/8-1:0] mask;
    } amo_beat_t;

endpackage

`default_nettype wire

// File: rtl/tluh_amo_beat_alu.sv
// ============================================================================
// Module   : tluh_amo_beat_alu
// Brief    : Combinational single-beat ALU: add with carry, compare, logic ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tluh_amo_beat_alu
    import tluh_pkg::*;
#(
    parameter int DW = TL_DW
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          carry_i,
    input  logic [2:0]    lop_i,
    output logic [DW-1:0] sum_o,
    output logic          carry_o,
    output logic          lt_u_o,
    output logic          eq_o,
    output logic [DW-1:0] logic_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{DW{1'b0}}, carry_i};
    assign lt_u_o           = a_i < b_i;
    assign eq_o             = a_i == b_i;

    always_comb begin
        logic_o = b_i;
        case (lop_i)
            XOR:     logic_o = a_i ^ b_i;
            OR:      logic_o = a_i | b_i;
            AND:     logic_o = a_i & b_i;
            default: logic_o = b_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tluh_amo_unit.sv
// ============================================================================
// Module   : tluh_amo_unit
// Brief    : Multi-beat TL-UH atomic unit; optional ovf_o via TLUH_AMO_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tluh_amo_unit
    import tluh_pkg::*;
#(
    parameter int DW        = TL_DW,
    parameter int MAX_BEATS = 2,
    parameter int BW        = DW / 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] op1_i,
    input  logic [DW-1:0] op2_i,
    input  logic [BW-1:0] mask_i,
    input  logic          last_i,
    input  logic          logic_i,
    input  logic [2:0]    param_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] result_o,
    output logic          out_last_o,
    output logic          err_o
`ifdef TLUH_AMO_OVERFLOW_EN
    ,
    output logic          ovf_o
`endif
);

    localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_BEATS - 1);

    amo_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, n_q, out_idx_q;
    logic          logic_q, carry_q, ltu_q, eq_q, err_q, drain_q;
    logic [2:0]    param_q;
    amo_beat_t     buf_q [MAX_BEATS];
    logic [DW-1:0] pre_q [MAX_BEATS];

    logic          w_acc, w_first, w_cin, w_logic, w_end;
    logic [2:0]    w_param;
    logic [DW-1:0] w_sum, w_lres;
    logic          w_cout, w_lt, w_eq;

    assign in_ready_o = (state_q == COLLECT);
    assign w_acc      = in_valid_i && in_ready_o;
    assign w_first    = (cnt_q == '0);
    assign w_cin      = w_first ? 1'b0 : carry_q;
    assign w_logic    = w_first ? logic_i : logic_q;
    assign w_param    = w_first ? param_i : param_q;
    assign w_end      = last_i || (cnt_q == LAST_IDX);

    tluh_amo_beat_alu #(.DW(DW)) u_alu (
        .a_i     (op1_i),
        .b_i     (op2_i),
        .carry_i (w_cin),
        .lop_i   (w_param),
        .sum_o   (w_sum),
        .carry_o (w_cout),
        .lt_u_o  (w_lt),
        .eq_o    (w_eq),
        .logic_o (w_lres)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (w_acc && !drain_q && w_end) state_d = EMIT;
            EMIT:    if (out_ready_i && out_idx_q == n_q) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= COLLECT;
            cnt_q     <= '0;
            n_q       <= '0;
            out_idx_q <= '0;
            logic_q   <= 1'b0;
            param_q   <= '0;
            carry_q   <= 1'b0;
            ltu_q     <= 1'b0;
            eq_q      <= 1'b0;
            err_q     <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_acc && drain_q) begin
                // Tail of an over-long operation: discard until its last beat.
                if (last_i) drain_q <= 1'b0;
            end else if (w_acc) begin
                buf_q[cnt_q] <= '{op1: op1_i, op2: op2_i, mask: mask_i};
                pre_q[cnt_q] <= w_logic ? w_lres : w_sum;
                carry_q      <= w_cout;
                eq_q         <= (w_first ? 1'b1 : eq_q) & w_eq;
                if (!w_eq)        ltu_q <= w_lt;
                else if (w_first) ltu_q <= 1'b0;
                if (w_first) begin
                    logic_q <= logic_i;
                    param_q <= param_i;
                end
                n_q     <= cnt_q;
                cnt_q   <= w_end ? '0 : cnt_q + 1'b1;
                err_q   <= !last_i && (cnt_q == LAST_IDX);
                drain_q <= !last_i && (cnt_q == LAST_IDX);
            end
            if (state_q == EMIT && out_ready_i)
                out_idx_q <= (out_idx_q == n_q) ? '0 : out_idx_q + 1'b1;
        end
    end

    amo_beat_t     w_cur, w_ms;
    logic          w_lt_s, w_sel1, w_bad, w_err;
    logic [DW-1:0] w_raw, w_res;

    always_comb begin
        w_cur  = buf_q[out_idx_q];
        w_ms   = buf_q[n_q];
        w_lt_s = (w_ms.op1[DW-1] != w_ms.op2[DW-1]) ? w_ms.op1[DW-1] : ltu_q;
        w_bad  = logic_q ? (param_q > 3'd3) : (param_q > 3'd4);
        w_err  = err_q | w_bad;
        w_sel1 = 1'b0;
        case (param_q)
            MIN:     w_sel1 = w_lt_s;
            MAX:     w_sel1 = !w_lt_s && !eq_q;
            MINU:    w_sel1 = ltu_q;
            MAXU:    w_sel1 = !ltu_q && !eq_q;
            default: w_sel1 = 1'b0;
        endcase
        w_raw = pre_q[out_idx_q];
        if (!logic_q && param_q != ADD) w_raw = w_sel1 ? w_cur.op1 : w_cur.op2;
        if (w_err) w_raw = w_cur.op1;
        // Masking follows compute so ADD carries still ripple through masked bytes.
        for (int i = 0; i < BW; i++)
            w_res[8*i +: 8] = w_cur.mask[i] ? w_raw[8*i +: 8] : w_cur.op1[8*i +: 8];
    end

    assign out_valid_o = (state_q == EMIT);
    assign out_last_o  = out_valid_o && (out_idx_q == n_q);
    assign result_o    = out_valid_o ? w_res : '0;
    assign err_o       = out_valid_o && w_err;

`ifdef TLUH_AMO_OVERFLOW_EN
    assign ovf_o = out_last_o && !logic_q && (param_q == ADD) && !w_err
                   && (w_ms.op1[DW-1] == w_ms.op2[DW-1])
                   && (pre_q[n_q][DW-1] != w_ms.op1[DW-1]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_tluh_amo_unit.sv
// ============================================================================
// Module   : tb_tluh_amo_unit
// Brief    : Directed self-checking bench for tluh_amo_unit (DW=32, 2 beats).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tluh_amo_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [3:0]  mask = '0;
    logic        last = 1'b0;
    logic        lg = 1'b0;
    logic [2:0]  prm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        out_last;
    logic        err;
`ifdef TLUH_AMO_OVERFLOW_EN
    logic        ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tluh_amo_unit #(.DW(32), .MAX_BEATS(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op1_i       (op1),
        .op2_i       (op2),
        .mask_i      (mask),
        .last_i      (last),
        .logic_i     (lg),
        .param_i     (prm),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .out_last_o  (out_last),
        .err_o       (err)
`ifdef TLUH_AMO_OVERFLOW_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called one time unit after a rising edge; returns one unit after the accepting edge.
    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic [3:0] m,
                        input logic l, input logic g, input logic [2:0] p);
        chk("in_ready_before_beat", {31'b0, in_ready}, 32'd1);
        chk("out_valid_before_beat", {31'b0, out_valid}, 32'd0);
        op1 = a; op2 = b; mask = m; last = l; lg = g; prm = p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res,
                              input logic lst, input logic e);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_result"}, result, res);
        chk({tag, "_last"}, {31'b0, out_last}, {31'b0, lst});
        chk({tag, "_err"}, {31'b0, err}, {31'b0, e});
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-beat ADD
        beat(32'h0000_0005, 32'h0000_0003, 4'hF, 1'b1, 1'b0, 3'd4);
        expect_out("add1", 32'h0000_0008, 1'b1, 1'b0);
        chk("add1_ready_after", {31'b0, in_ready}, 32'd1);

        // 64-bit ADD with carry across beats
        beat(32'hFFFF_FFFF, 32'h0000_0001, 4'hF, 1'b0, 1'b0, 3'd4);
        beat(32'h0000_0000, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 3'd4);
        expect_out("add64_b0", 32'h0000_0000, 1'b0, 1'b0);
`ifdef TLUH_AMO_OVERFLOW_EN
        chk("add64_ovf", {31'b0, ovf}, 32'd0);
`endif
        expect_out("add64_b1", 32'h0000_0001, 1'b1, 1'b0);

        // 64-bit signed MIN: 0x8000..0 vs 1
        beat(32'h0000_0000, 32'h0000_0001, 4'hF, 1'b0, 1'b0, 3'd0);
        beat(32'h8000_0000, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 3'd0);
        expect_out("min_b0", 32'h0000_0000, 1'b0, 1'b0);
        expect_out("min_b1", 32'h8000_0000, 1'b1, 1'b0);

        // MINU on the same operands
        beat(32'h0000_0000, 32'h0000_0001, 4'hF, 1'b0, 1'b0, 3'd2);
        beat(32'h8000_0000, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 3'd2);
        expect_out("minu_b0", 32'h0000_0001, 1'b0, 1'b0);
        expect_out("minu_b1", 32'h0000_0000, 1'b1, 1'b0);

        // Masked SWAP
        beat(32'hAABB_CCDD, 32'h1122_3344, 4'b0101, 1'b1, 1'b1, 3'd3);
        expect_out("swap", 32'hAA22_CC44, 1'b1, 1'b0);

        // MAXU with 3 cycles of backpressure
        out_ready = 1'b0;
        beat(32'h0000_0000, 32'h0000_0001, 4'hF, 1'b0, 1'b0, 3'd3);
        beat(32'h8000_0000, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 3'd3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", result, 32'h0000_0000);
            chk("bp_last", {31'b0, out_last}, 32'd0);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        expect_out("maxu_b0", 32'h0000_0000, 1'b0, 1'b0);
        expect_out("maxu_b1", 32'h8000_0000, 1'b1, 1'b0);

        // Illegal logical opcode
        beat(32'h1234_5678, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 3'd5);
        expect_out("badop", 32'h1234_5678, 1'b1, 1'b1);

        // Too many beats: error result, then the trailing beat is swallowed
        beat(32'h1111_1111, 32'h2222_2222, 4'hF, 1'b0, 1'b1, 3'd0);
        beat(32'h3333_3333, 32'h4444_4444, 4'hF, 1'b0, 1'b1, 3'd0);
        expect_out("ovl_b0", 32'h1111_1111, 1'b0, 1'b1);
        expect_out("ovl_b1", 32'h3333_3333, 1'b1, 1'b1);
        beat(32'h5555_5555, 32'h6666_6666, 4'hF, 1'b1, 1'b1, 3'd0);
        chk("drain_no_output", {31'b0, out_valid}, 32'd0);

        // Masked ADD after drain: carry ripples from masked byte 0
        beat(32'h0000_00FF, 32'h0000_0001, 4'b0010, 1'b1, 1'b0, 3'd4);
        expect_out("madd", 32'h0000_01FF, 1'b1, 1'b0);

        // Reset during EMIT
        out_ready = 1'b0;
        beat(32'h0000_0001, 32'h0000_0001, 4'hF, 1'b1, 1'b0, 3'd4);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        beat(32'hF0F0_F0F0, 32'hFFFF_0000, 4'hF, 1'b1, 1'b1, 3'd0);
        expect_out("xor", 32'h0F0F_F0F0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
